onehot_encoder_pipe: RTL

Registered, parametrised successor to the team's 16-to-4 combinational encoder. It accepts a WIDTH-bit request vector on a valid/ready handshake and produces a binary index one cycle later. It supports three selection modes: strict one-hot, fixed lowest-index priority, and round-robin. Invalid-pattern flags are reported alongside the result. It sits between request sources (interrupt lines, arbiter requests) and downstream index consumers that may apply backpressure.

---
 rtl/onehot_encoder_pipe_if.sv | 50 +++++
 rtl/onehot_encoder_pipe.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/onehot_encoder_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : onehot_encoder_pipe_if
//  Description : Request/result handshake bundle for onehot_encoder_pipe.
//                The master side drives requests and consumes results; the
//                slave side is the encoder itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface onehot_encoder_pipe_if #(
   parameter int WIDTH = 16
);
   localparam int OUT_W = $clog2(WIDTH);

   logic             enable;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] encoder_in;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] binary_out;
   logic             zero_err;
   logic             multi_err;

   // Request source / result consumer side.
   modport master (
      output enable,
      output in_valid,
      output encoder_in,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  binary_out,
      input  zero_err,
      input  multi_err
   );

   // Encoder side.
   modport slave (
      input  enable,
      input  in_valid,
      input  encoder_in,
      input  out_ready,
      output in_ready,
      output out_valid,
      output binary_out,
      output zero_err,
      output multi_err
   );
endinterface
`default_nettype wire

// File: rtl/onehot_encoder_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : onehot_encoder_pipe
//  Description : Registered WIDTH-to-index encoder behind a valid/ready
//                handshake. MODE 0 = strict one-hot, MODE 1 = lowest index
//                wins, MODE 2 = round-robin starting at an internal pointer.
//                All-zero and multi-bit requests are flagged in every mode.
//  Revision    : 1.0 - initial release
// ============================================================================
module onehot_encoder_pipe #(
   parameter int WIDTH = 16,
   parameter int MODE  = 0
) (
   input wire logic              clk,
   input wire logic              reset,
   onehot_encoder_pipe_if.slave  bus
);

   localparam int              OUT_W     = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] c_REQ_ONE = WIDTH'(1);
   localparam logic [OUT_W-1:0] c_PTR_ONE = OUT_W'(1);

   // Elaboration-time parameter sanity checks.
   generate
      if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
         $error("onehot_encoder_pipe: WIDTH must be a power of two >= 2");
      end
      if (MODE < 0 || MODE > 2) begin : g_bad_mode
         $error("onehot_encoder_pipe: MODE must be 0, 1 or 2");
      end
   endgenerate

   // Index of the lowest set bit; 0 when nothing is set.
   function automatic logic [OUT_W-1:0] f_lowest(input logic [WIDTH-1:0] v);
      logic [OUT_W-1:0] idx;
      idx = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (v[i]) begin
            idx = OUT_W'(i);
         end
      end
      return idx;
   endfunction

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic             valid_q, valid_d;
   logic [OUT_W-1:0] bin_q,   bin_d;
   logic             zero_q,  zero_d;
   logic             multi_q, multi_d;
   logic [OUT_W-1:0] ptr_q,   ptr_d;

   // ------------------------------------------------------------------------
   // Request decode (shared by all modes)
   // ------------------------------------------------------------------------
   logic [WIDTH-1:0] req_w;
   logic             zero_w;
   logic             multi_w;
   logic [OUT_W-1:0] low_w;
   logic [OUT_W-1:0] sel_w;      // index to load on accept
   logic [OUT_W-1:0] ptr_adv_w;  // pointer to load on accept
   logic             in_ready_w;
   logic             accept_w;
   logic             deliver_w;

   assign req_w   = bus.encoder_in;
   assign zero_w  = ~|req_w;
   // Clearing the lowest set bit leaves something only if two or more were set.
   assign multi_w = |(req_w & (req_w - c_REQ_ONE));
   assign low_w   = f_lowest(req_w);

   // ------------------------------------------------------------------------
   // Mode-specific selection
   // ------------------------------------------------------------------------
   generate
      if (MODE == 0) begin : g_strict
         // Invalid patterns collapse to 0, same as the legacy encoder.
         assign sel_w     = (zero_w || multi_w) ? '0 : low_w;
         assign ptr_adv_w = ptr_q;
      end else if (MODE == 1) begin : g_prio
         assign sel_w     = low_w;
         assign ptr_adv_w = ptr_q;
      end else begin : g_rr
         logic [WIDTH-1:0] rot_w;  // request rotated so bit 0 is at ptr
         logic [OUT_W-1:0] off_w;  // winner distance from ptr
         logic [OUT_W-1:0] win_w;

         // Rotate so the search always starts at bit 0; OUT_W-bit index
         // arithmetic gives the wrap from WIDTH-1 back to 0 for free.
         always_comb begin
            rot_w = '0;
            for (int i = 0; i < WIDTH; i++) begin
               rot_w[i] = req_w[OUT_W'(i) + ptr_q];
            end
         end

         assign off_w     = f_lowest(rot_w);
         assign win_w     = ptr_q + off_w;
         assign sel_w     = zero_w ? '0 : win_w;
         assign ptr_adv_w = zero_w ? ptr_q : (win_w + c_PTR_ONE);
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Handshake
   // ------------------------------------------------------------------------
   // Ready depends only on enable, the output stage and reset, never on
   // the incoming request.
   assign in_ready_w = !reset && bus.enable && (!valid_q || bus.out_ready);
   assign accept_w   = bus.in_valid && in_ready_w;
   assign deliver_w  = valid_q && bus.out_ready;

   // Next-state: load on accept, drop valid on a delivery without refill,
   // otherwise hold everything (including the round-robin pointer).
   always_comb begin
      valid_d = valid_q;
      bin_d   = bin_q;
      zero_d  = zero_q;
      multi_d = multi_q;
      ptr_d   = ptr_q;
      if (accept_w) begin
         valid_d = 1'b1;
         bin_d   = sel_w;
         zero_d  = zero_w;
         multi_d = multi_w;
         ptr_d   = ptr_adv_w;
      end else if (deliver_w) begin
         valid_d = 1'b0;
      end
   end

   // State register; reset wins over everything and discards a stalled result.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         bin_q   <= '0;
         zero_q  <= 1'b0;
         multi_q <= 1'b0;
         ptr_q   <= '0;
      end else begin
         valid_q <= valid_d;
         bin_q   <= bin_d;
         zero_q  <= zero_d;
         multi_q <= multi_d;
         ptr_q   <= ptr_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign bus.in_ready   = in_ready_w;
   assign bus.out_valid  = valid_q;
   assign bus.binary_out = bin_q;
   assign bus.zero_err   = zero_q;
   assign bus.multi_err  = multi_q;

endmodule
`default_nettype wire
